// File: rtl/otp_stream_ctrl_pkg.sv
// Shared constants and FSM state type for the one-time-pad stream controller.
// Optional build macro: OTP_ZEROIZE_EN (scrub consumed pad material).
package otp_stream_ctrl_pkg;

  localparam int KEY_SIZE      = 16;
  localparam int OTP_KEY_DEPTH = 8;
  localparam int OTP_CRYPT_LAT = 1;

  typedef enum logic [1:0] {
    OTP_ST_IDLE = 2'd0,
    OTP_ST_RUN  = 2'd1,
    OTP_ST_HOLD = 2'd2
  } otp_state_e;

endpackage

// File: rtl/otp_key_fifo.sv
// Circular pad-word pool with push/pop, occupancy count and full/empty flags.
// Optional build macro: OTP_ZEROIZE_EN (popped slot cleared on the pop edge).
module otp_key_fifo
  import otp_stream_ctrl_pkg::*;
#(
  parameter int WIDTH = KEY_SIZE,
  parameter int DEPTH = OTP_KEY_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full && !rst;
  assign do_pop   = pop && !empty && !rst;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Push and pop never hit the same slot: that needs an empty or full pool.
  always_ff @(posedge clk) begin
`ifdef OTP_ZEROIZE_EN
    if (do_pop) mem[rd_ptr] <= '0;
`endif
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/otp_stream_ctrl.sv
// Pairs each message word with a fresh pad word, drives the cryptor, returns result.
// Optional build macro: OTP_ZEROIZE_EN (cryptor inputs cleared on result capture).
module otp_stream_ctrl
  import otp_stream_ctrl_pkg::*;
#(
  parameter int WIDTH     = KEY_SIZE,
  parameter int KEY_DEPTH = OTP_KEY_DEPTH,
  parameter int CRYPT_LAT = OTP_CRYPT_LAT,
  localparam int CW = $clog2(KEY_DEPTH) + 1,
  localparam int LW = (CRYPT_LAT > 1) ? $clog2(CRYPT_LAT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] key_in,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [WIDTH-1:0] msg_in,
  input  logic             msg_valid,
  output logic             msg_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    keys_avail,
  output logic             key_exhausted,
  output logic [WIDTH-1:0] cry_msg,
  output logic [WIDTH-1:0] cry_key,
  input  logic [WIDTH-1:0] cry_out
);

  otp_state_e       state;
  otp_state_e       state_nxt;
  logic [LW-1:0]    lat_cnt;
  logic [WIDTH-1:0] pad;
  logic             full;
  logic             empty;
  logic             accept;
  logic             capture;

  otp_key_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (KEY_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (key_valid),
    .push_data (key_in),
    .pop       (accept),
    .pop_data  (pad),
    .count     (keys_avail),
    .full      (full),
    .empty     (empty)
  );

  assign key_ready     = !full;
  assign key_exhausted = empty;

  always_comb begin
    state_nxt = state;
    msg_ready = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    unique case (state)
      OTP_ST_IDLE: begin
        msg_ready = !empty;
        if (msg_valid && !empty) begin
          accept    = 1'b1;
          state_nxt = OTP_ST_RUN;
        end
      end
      OTP_ST_RUN: begin
        if (lat_cnt == LW'(CRYPT_LAT - 1)) begin
          capture   = 1'b1;
          state_nxt = OTP_ST_HOLD;
        end
      end
      OTP_ST_HOLD: begin
        if (out_ready) state_nxt = OTP_ST_IDLE;
      end
      default: state_nxt = OTP_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= OTP_ST_IDLE;
      lat_cnt   <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      cry_msg   <= '0;
      cry_key   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cry_msg <= msg_in;
        cry_key <= pad;
        lat_cnt <= '0;
      end
      if (state == OTP_ST_RUN && !capture) lat_cnt <= lat_cnt + 1'b1;
      if (capture) begin
        data_out  <= cry_out;
        out_valid <= 1'b1;
`ifdef OTP_ZEROIZE_EN
        cry_msg   <= '0;
        cry_key   <= '0;
`endif
      end
      if (state == OTP_ST_HOLD && out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/otp_stream_ctrl.md
Name: otp_stream_ctrl

Overview:
Sequencing controller for the one-time-pad cryptor datapath. Holds a pool of pre-loaded pad words, pairs each accepted message word with the next unused pad word, and drives the cryptor's msg/key inputs. It waits out the cryptor's registered latency, then returns the result over a valid/ready handshake. It guarantees each pad word is consumed exactly once and never reused.

Parameters:
WIDTH, `KEY_SIZE (16), width of message, pad and result words
KEY_DEPTH, 8, pad pool entries; power of two, minimum 2
CRYPT_LAT, 1, cryptor clock-cycle latency from msg/key to out, minimum 1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
key_in  in  WIDTH  pad word to load
key_valid  in  1  key_in valid
key_ready  out  1  pool can accept a pad word
msg_in  in  WIDTH  plaintext or ciphertext word
msg_valid  in  1  msg_in valid
msg_ready  out  1  controller accepts msg_in this cycle
data_out  out  WIDTH  cryptor result
out_valid  out  1  data_out valid
out_ready  in  1  downstream accepts data_out
keys_avail  out  $clog2(KEY_DEPTH)+1  unused pad words in pool
key_exhausted  out  1  pool empty (level)
cry_msg  out  WIDTH  to cryptor msg
cry_key  out  WIDTH  to cryptor key
cry_out  in  WIDTH  from cryptor out

Behaviour:
- Single clock clk; rst synchronous, active-high; all state updates on rising clk.
- Reset: state IDLE; pool pointers and count 0; key_ready=1, msg_ready=0, out_valid=0, data_out=0, cry_msg=0, cry_key=0, keys_avail=0, key_exhausted=1. Pool contents discarded. A reset mid-operation drops the in-flight message, its pad word and any pending output.
- Pool: circular buffer with wr_ptr, rd_ptr and count. key_ready = (count < KEY_DEPTH). Push on key_valid && key_ready. Pointers wrap modulo KEY_DEPTH.
- Push and pop in the same cycle: count unchanged, both pointers advance. A full pool never pushes, because key_ready=0.
- keys_avail = count. key_exhausted = (count == 0).
- FSM states: IDLE, RUN, HOLD.
- IDLE: msg_ready = (count > 0). On msg_valid && msg_ready (cycle T):
  - cry_msg <= msg_in
  - cry_key <= pool[rd_ptr]
  - pop the pad word
  - latency counter <= 0
  - go to RUN
- While the pool is empty, msg_ready=0 and messages stall indefinitely; no default key is ever used.
- RUN: cry_msg and cry_key held stable. Counter increments each cycle. At end of cycle T+CRYPT_LAT: data_out <= cry_out, out_valid <= 1, go to HOLD. With CRYPT_LAT=1, out_valid is first high in cycle T+2.
- HOLD: data_out and out_valid held until out_ready. On out_valid && out_ready: out_valid <= 0, go to IDLE. The next message can be accepted in the cycle after the handshake.
- Throughput: one word per CRYPT_LAT+2 cycles, no overlap.
- msg_ready is 0 in RUN and HOLD. Key loading continues in all states.
- Width: all datapaths are WIDTH bits; no arithmetic on data. count is $clog2(KEY_DEPTH)+1 bits.

Optional Feature:
Macro OTP_ZEROIZE_EN.
- Defined:
  - A popped pool slot is written to 0 on the same edge as the pop.
  - cry_key is cleared to 0 on the edge that captures data_out.
  - cry_msg is cleared to 0 on the same edge.
  - Consumed pad material is never observable after use.
- Undefined: consumed slots retain their old contents, and cry_key/cry_msg hold their last value until the next accept. Handshake timing is identical in both builds.

Decomposition:
- constants.vh gains:
  - OTP_KEY_DEPTH and OTP_CRYPT_LAT defaults
  - FSM state encodings OTP_ST_IDLE=2'd0, OTP_ST_RUN=2'd1, OTP_ST_HOLD=2'd2
- KEY_SIZE stays the single word-width source.
- One sub-module, otp_key_fifo: the pad pool, with push/pop, count, the full/empty flags and the optional zeroize-on-pop. otp_stream_ctrl contains the FSM and the cryptor-side registers.

Test Plan:
1. Reset, then load key 0xFFFF and send msg 0x0000 → out_valid in cycle T+2 with data_out=0xFFFF; keys_avail 1→0; key_exhausted=1 afterwards.
2. Load 0x5555 then 0x5555; send 0xAAAA then 0x5555 → outputs 0xFFFF then 0x0000, in order; each pad used once; a third msg_valid stalls with msg_ready=0 until a new key is loaded.
3. Fill the pool with 8 keys → key_ready=0 and keys_avail=8. Push a 9th while a message is accepted in the same cycle → that cycle is not a push (key_ready=0). The following cycle push succeeds. The 9th key is the one consumed 9th, confirming wrap-around.
4. Backpressure: hold out_ready=0 for 5 cycles with key 0x5555 and msg 0xFFFF → data_out=0xAAAA held stable; msg_ready=0 throughout; IDLE is reached the cycle after out_ready=1.
5. Assert rst during RUN → next cycle all outputs at reset values; keys_avail=0; no out_valid is produced for the dropped message.
6. With OTP_ZEROIZE_EN: after capture, cry_key=0 and cry_msg=0, and the popped slot reads 0. Without it, cry_key retains the last pad.
